// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: FSM encodings,
// processor event channel indices and a constant-friendly clog2 helper.
package perf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam int CH_INST  = 0;
   localparam int CH_ICREQ = 1;
   localparam int CH_ICHIT = 2;
   localparam int CH_DCREQ = 3;
   localparam int CH_DCHIT = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/perf_counter_ch.sv
// One event counter with synchronous clear, saturate-or-wrap overflow and a sticky flag.
// Registered count; cnt_nxt exposes the value the register takes at the coming edge.
module perf_counter_ch #(
   parameter int CNT_W    = 32,
   parameter int SAT_MODE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic             ovf
);

   logic [CNT_W-1:0] cnt;
   logic             ovf_nxt;

   always_comb begin
      cnt_nxt = cnt;
      ovf_nxt = ovf;
      if (clr) begin
         cnt_nxt = '0;
         ovf_nxt = 1'b0;
      end else if (inc) begin
         if (cnt == {CNT_W{1'b1}}) begin
            // Any increment attempt at all-ones is an overflow, in either mode.
            ovf_nxt = 1'b1;
            cnt_nxt = (SAT_MODE != 0) ? cnt : '0;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         ovf <= ovf_nxt;
      end
   end

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle counter plus NUM_CH event counters gated by an IDLE/RUN/HALTED FSM.
// Read data registered one cycle after rd_en and includes that cycle's events.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int CNT_W    = 32,
   parameter int SAT_MODE = 1,
   parameter int SEL_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt,
   input  logic              clear,
   input  logic [NUM_CH-1:0] event_vec,
   input  logic [SEL_W-1:0]  rd_sel,
   input  logic              rd_en,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_valid,
   output logic [NUM_CH:0]   ovf_flags,
   output logic [1:0]        state_o,
   output logic              halted
);

   localparam int IDX_W = clog2(NUM_CH + 1);

   state_t           state;
   state_t           state_nxt;
   logic             count_en;
   logic [NUM_CH:0]  inc;
   logic [CNT_W-1:0] cnt_nxt [NUM_CH+1];
   logic [CNT_W-1:0] rd_mux;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = ST_IDLE;
      if (!clear) begin
         case (state)
            ST_IDLE:   state_nxt = start ? ST_RUN : ST_IDLE;
            ST_RUN:    state_nxt = halt ? ST_HALTED : ST_RUN;
            ST_HALTED: state_nxt = start ? ST_RUN : ST_HALTED;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   // The halt cycle itself still counts; clear discards the cycle's events.
   always_comb begin
      count_en = (state == ST_RUN) && !clear;
      halted   = (state == ST_HALTED);
      state_o  = state;
   end

   always_comb begin
      inc[0]        = count_en;
      inc[NUM_CH:1] = event_vec & {NUM_CH{count_en}};
   end

   for (genvar g = 0; g <= NUM_CH; g++) begin : g_ch
      perf_counter_ch #(
         .CNT_W    (CNT_W),
         .SAT_MODE (SAT_MODE)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .inc     (inc[g]),
         .clr     (clear),
         .cnt_nxt (cnt_nxt[g]),
         .ovf     (ovf_flags[g])
      );
   end

   // Select from next-state values so a read includes events of its own cycle.
   always_comb begin
      rd_mux = '0;
      if (rd_sel <= SEL_W'(NUM_CH)) rd_mux = cnt_nxt[rd_sel[IDX_W-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= rd_mux;
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: a 32-bit saturating bank plus 4-bit saturating and wrapping
// banks driven from the same stimulus.
module tb_perf_counter_bank;
   import perf_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start, halt, clear, rd_en;
   logic [7:0]  event_vec;
   logic [3:0]  rd_sel;

   logic [31:0] rd_data_m;
   logic [3:0]  rd_data_s, rd_data_w;
   logic        rd_valid_m, rd_valid_s, rd_valid_w;
   logic [8:0]  ovf_m, ovf_s, ovf_w;
   logic [1:0]  state_m, state_s, state_w;
   logic        halted_m, halted_s, halted_w;

   int checks = 0;
   int errors = 0;

   perf_counter_bank #(.NUM_CH(8), .CNT_W(32), .SAT_MODE(1), .SEL_W(4)) u_main (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clear(clear),
      .event_vec(event_vec), .rd_sel(rd_sel), .rd_en(rd_en),
      .rd_data(rd_data_m), .rd_valid(rd_valid_m), .ovf_flags(ovf_m),
      .state_o(state_m), .halted(halted_m));

   perf_counter_bank #(.NUM_CH(8), .CNT_W(4), .SAT_MODE(1), .SEL_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clear(clear),
      .event_vec(event_vec), .rd_sel(rd_sel), .rd_en(rd_en),
      .rd_data(rd_data_s), .rd_valid(rd_valid_s), .ovf_flags(ovf_s),
      .state_o(state_s), .halted(halted_s));

   perf_counter_bank #(.NUM_CH(8), .CNT_W(4), .SAT_MODE(0), .SEL_W(4)) u_wrap (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clear(clear),
      .event_vec(event_vec), .rd_sel(rd_sel), .rd_en(rd_en),
      .rd_data(rd_data_w), .rd_valid(rd_valid_w), .ovf_flags(ovf_w),
      .state_o(state_w), .halted(halted_w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start, halt, clear;
      logic [7:0]  ev;
      logic        rd_en;
      logic [3:0]  sel;
      logic [31:0] exp_data;
      logic        exp_valid;
      logic [1:0]  exp_state;
      logic        exp_halted;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic st, input logic ht, input logic cl,
                       input logic [7:0] ev, input logic re, input logic [3:0] sel);
      @(negedge clk);
      start = st; halt = ht; clear = cl; event_vec = ev; rd_en = re; rd_sel = sel;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic st, input logic ht, input logic [7:0] ev,
                               input logic re, input logic [3:0] sel, input logic [31:0] d,
                               input logic v, input logic [1:0] s, input logic h);
      vec_t r;
      r.start = st; r.halt = ht; r.clear = 1'b0; r.ev = ev; r.rd_en = re; r.sel = sel;
      r.exp_data = d; r.exp_valid = v; r.exp_state = s; r.exp_halted = h;
      return r;
   endfunction

   initial begin
      rst_n = 1'b0; start = 0; halt = 0; clear = 0; event_vec = '0; rd_en = 0; rd_sel = '0;

      // Tests 1 and 2: basic run/halt counting, halted freeze, resume.
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 8'h01 << CH_INST, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 2, 1));
      vecs.push_back(mk(0, 0, 8'h00, 1, 1, 5, 1, 2, 1));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 6, 1, 2, 1));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 6, 0, 2, 1));
      for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 8'hFF, 0, 0, 6, 0, 2, 1));
      vecs.push_back(mk(0, 0, 8'h00, 1, 2, 0, 1, 2, 1));
      vecs.push_back(mk(0, 0, 8'h00, 1, 1, 5, 1, 2, 1));
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 5, 0, 1, 0));
      vecs.push_back(mk(0, 0, 8'h01 << CH_ICREQ, 1, 2, 1, 1, 1, 0));
      vecs.push_back(mk(0, 0, 8'h01 << CH_ICREQ, 0, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 8'h01 << CH_ICREQ, 1, 0, 9, 1, 1, 0));
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 9, 0, 2, 1));
      vecs.push_back(mk(0, 0, 8'h00, 1, 2, 3, 1, 2, 1));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 10, 1, 2, 1));

      #12;
      chk("reset_rd_data", rd_data_m, 0);
      chk("reset_rd_valid", rd_valid_m, 0);
      chk("reset_state", state_m, 0);
      chk("reset_halted", halted_m, 0);
      chk("reset_ovf", ovf_m, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].start, vecs[i].halt, vecs[i].clear, vecs[i].ev, vecs[i].rd_en, vecs[i].sel);
         chk($sformatf("vec%0d_data", i), rd_data_m, vecs[i].exp_data);
         chk($sformatf("vec%0d_valid", i), rd_valid_m, vecs[i].exp_valid);
         chk($sformatf("vec%0d_state", i), state_m, vecs[i].exp_state);
         chk($sformatf("vec%0d_halted", i), halted_m, vecs[i].exp_halted);
         chk($sformatf("vec%0d_ovf", i), ovf_m, 0);
      end

      // Test 3: 4-bit saturation on channel 0; cycle counter saturates as well.
      step(0, 0, 1, 8'h00, 0, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      repeat (20) step(0, 0, 0, 8'h01, 0, 0);
      step(0, 1, 0, 8'h00, 0, 0);
      step(0, 0, 0, 8'h00, 1, 1);
      chk("sat_ch0_data", rd_data_s, 15);
      chk("sat_ch0_ovf", ovf_s[1], 1);
      chk("sat_cyc_ovf", ovf_s[0], 1);
      chk("sat_other_ovf", ovf_s[8:2], 0);
      chk("main_ch0_data", rd_data_m, 20);
      chk("main_no_ovf", ovf_m, 0);
      step(0, 0, 0, 8'h00, 1, 0);
      chk("sat_cyc_data", rd_data_s, 15);

      // Test 4: 4-bit wrap on channel 2, sticky flag across further events.
      step(0, 0, 1, 8'h00, 0, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      repeat (17) step(0, 0, 0, 8'h04, 0, 0);
      step(0, 1, 0, 8'h00, 0, 0);
      step(0, 0, 0, 8'h00, 1, 3);
      chk("wrap_ch2_data", rd_data_w, 1);
      chk("wrap_ch2_ovf", ovf_w[3], 1);
      chk("wrap_ch0_ovf", ovf_w[1], 0);
      chk("main_ch2_data", rd_data_m, 17);
      chk("sat_ch2_data", rd_data_s, 15);
      step(0, 0, 0, 8'h00, 1, 0);
      chk("wrap_cyc_data", rd_data_w, 2);
      chk("wrap_cyc_ovf", ovf_w[0], 1);
      step(1, 0, 0, 8'h00, 0, 0);
      repeat (5) step(0, 0, 0, 8'h04, 0, 0);
      step(0, 1, 0, 8'h00, 0, 0);
      step(0, 0, 0, 8'h00, 1, 3);
      chk("wrap_ch2_data2", rd_data_w, 6);
      chk("wrap_ch2_sticky", ovf_w[3], 1);

      // Test 5: clear beats start and events; out-of-range selects return 0.
      step(1, 0, 0, 8'h00, 0, 0);
      step(0, 0, 0, 8'hFF, 0, 0);
      step(1, 0, 1, 8'hFF, 0, 0);
      chk("clr_state", state_m, 0);
      step(0, 0, 0, 8'h00, 1, 0);
      chk("clr_data", rd_data_m, 0);
      chk("clr_valid", rd_valid_m, 1);
      chk("clr_state2", state_m, 0);
      chk("clr_ovf_m", ovf_m, 0);
      chk("clr_ovf_s", ovf_s, 0);
      chk("clr_ovf_w", ovf_w, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      step(0, 0, 0, 8'hFF, 0, 0);
      step(0, 0, 0, 8'hFF, 1, 0);
      chk("run_cyc_data", rd_data_m, 2);
      step(0, 0, 0, 8'hFF, 1, 9);
      chk("oor9_data", rd_data_m, 0);
      chk("oor9_valid", rd_valid_m, 1);
      step(0, 0, 0, 8'h00, 1, 15);
      chk("oor15_data", rd_data_m, 0);

      // Test 6: asynchronous reset between edges while running.
      step(0, 0, 0, 8'h01, 1, 0);
      chk("pre_rst_data", rd_data_m, 5);
      @(negedge clk);
      start = 0; halt = 0; clear = 0; event_vec = 8'h01; rd_en = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data", rd_data_m, 0);
      chk("arst_valid", rd_valid_m, 0);
      chk("arst_state", state_m, 0);
      chk("arst_halted", halted_m, 0);
      chk("arst_ovf", ovf_m, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 8'h01, 0, 0);
      step(0, 0, 0, 8'h01, 1, 1);
      chk("post_rst_data", rd_data_m, 0);
      chk("post_rst_state", state_m, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      step(0, 0, 0, 8'h01, 0, 0);
      step(0, 0, 0, 8'h01, 0, 0);
      step(0, 1, 0, 8'h00, 0, 0);
      step(0, 0, 0, 8'h00, 1, 1);
      chk("resume_ch0", rd_data_m, 2);
      step(0, 0, 0, 8'h00, 1, 0);
      chk("resume_cyc", rd_data_m, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
